// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier controller.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand/product handshake bundle for seq_mult_ctrl.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  // Stimulus / upstream control side
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  // Multiplier controller side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/seq_mult_ctrl_add_cout.sv
// WIDTH-bit adder exposing its carry-out; the one adder the multiplier reuses every cycle.
module add_cout #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b};

endmodule

// File: rtl/seq_mult_ctrl.sv
// Iterative unsigned shift-and-add multiplier controller with valid/ready on both sides.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | in_ready high, waiting for an operand pair
// RUN     | one add/shift iteration per clock, rem counts down to 1
// DONE    | product held, out_valid high until the consumer takes it
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  seq_mult_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     mplr;
  logic [CW-1:0]        rem;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [WIDTH-1:0]     acc_n;
  logic [WIDTH-1:0]     mplr_n;
  logic [CW-1:0]        rem_n;
  logic [WIDTH-1:0]     rest_mask;
  logic                 rest_zero;
  logic [2*WIDTH-1:0]   early_val;

  assign addend = mplr[0] ? mcand : '0;

  add_cout #(.WIDTH(WIDTH)) u_add (
    .op_a (acc),
    .op_b (addend),
    .sum  (sum),
    .cout (cout)
  );

  // Next shift step: carry-out becomes the new acc MSB, sum LSB moves into mplr.
  // The low rem_n bits of mplr_n are the multiplier bits still to be consumed.
  always_comb begin
    acc_n     = {cout, sum[WIDTH-1:1]};
    mplr_n    = {sum[0], mplr[WIDTH-1:1]};
    rem_n     = rem - CW'(1);
    rest_mask = (WIDTH'(1) << rem_n) - WIDTH'(1);
    rest_zero = ((mplr_n & rest_mask) == '0);
    early_val = {acc_n, mplr_n} >> rem_n;
  end

  // Controller FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
      mcand       <= '0;
      acc         <= '0;
      mplr        <= '0;
      rem         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            mcand      <= bus.a;
            mplr       <= bus.b;
            acc        <= '0;
            rem        <= CW'(WIDTH);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc  <= acc_n;
          mplr <= mplr_n;
          rem  <= rem_n;
          if (rem == CW'(1)) begin
            product_q   <= {acc_n, mplr_n};
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end else if (EARLY_EXIT && rest_zero) begin
            // Remaining multiplier bits are zero: apply the outstanding shifts in one go.
            product_q   <= early_val;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: one full-length instance and one early-exit instance.
module tb_seq_mult_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_mult_ctrl_if #(.WIDTH(W)) bus0 ();
  seq_mult_ctrl_if #(.WIDTH(W)) bus1 ();

  seq_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  seq_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_early (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ov(input int sel);
    return (sel == 0) ? 32'(bus0.out_valid) : 32'(bus1.out_valid);
  endfunction

  function automatic logic [31:0] ir(input int sel);
    return (sel == 0) ? 32'(bus0.in_ready) : 32'(bus1.in_ready);
  endfunction

  function automatic logic [31:0] pr(input int sel);
    return (sel == 0) ? 32'(bus0.product) : 32'(bus1.product);
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (sel == 0) begin
      bus0.in_valid = v; bus0.a = a; bus0.b = b;
    end else begin
      bus1.in_valid = v; bus1.a = a; bus1.b = b;
    end
  endtask

  task automatic set_ordy(input int sel, input logic v);
    if (sel == 0) bus0.out_ready = v;
    else          bus1.out_ready = v;
  endtask

  // Steps until out_valid is seen, at most 60 cycles; returns the number of steps taken.
  task automatic wait_valid(input int sel, output int cyc);
    cyc = 0;
    while (ov(sel) !== 32'd1 && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  // One complete transaction: accept, wait for the product, take it.
  task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp, input int lat, input string tag);
    int cyc;
    chk({tag, "_in_ready"}, ir(sel), 32'd1);
    set_in(sel, 1'b1, a, b);
    step();
    set_in(sel, 1'b0, 8'h00, 8'h00);
    wait_valid(sel, cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_product"}, pr(sel), 32'(exp));
    set_ordy(sel, 1'b1);
    step();
    set_ordy(sel, 1'b0);
    chk({tag, "_valid_drop"}, ov(sel), 32'd0);
  endtask

  initial begin
    int cyc;
    int pa;
    int pb;
    logic seen;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_in(0, 1'b0, 8'h00, 8'h00);
    set_in(1, 1'b0, 8'h00, 8'h00);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov(0), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_product", pr(0), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", ir(0), 32'd1);
    chk("idle_busy", 32'(bus0.busy), 32'd0);

    // Basic product, full-width carry path, zero operands
    run_op(0, 8'd4,   8'd2,   8,     W, "t1_4x2");
    run_op(0, 8'd255, 8'd255, 65025, W, "t2_255x255");
    run_op(0, 8'd0,   8'd200, 0,     W, "t3_0x200");
    run_op(0, 8'd123, 8'd0,   0,     W, "t3_123x0");

    // Held product with back-pressure and noisy in_valid
    set_in(0, 1'b1, 8'd4, 8'd102);
    step();
    set_in(0, 1'b0, 8'd0, 8'd0);
    chk("t4_busy", 32'(bus0.busy), 32'd1);
    wait_valid(0, cyc);
    chk("t4_latency", 32'(cyc), 32'(W));
    for (int i = 0; i < 5; i++) begin
      set_in(0, ~bus0.in_valid, 8'd9, 8'd9);
      step();
      chk("t4_hold_product", pr(0), 32'd408);
      chk("t4_hold_in_ready", ir(0), 32'd0);
      chk("t4_hold_valid", ov(0), 32'd1);
    end
    set_ordy(0, 1'b1);
    step();
    set_ordy(0, 1'b0);
    set_in(0, 1'b0, 8'd0, 8'd0);
    chk("t4_handshake_drop", ov(0), 32'd0);
    chk("t4_back_idle", ir(0), 32'd1);
    step();
    chk("t4_single_handshake", ov(0), 32'd0);
    chk("t4_not_restarted", 32'(bus0.busy), 32'd0);
    chk("t4_product_kept", pr(0), 32'd408);

    // Reset in the middle of a run
    set_in(0, 1'b1, 8'd4, 8'd12);
    step();
    set_in(0, 1'b0, 8'd0, 8'd0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("t5_async_product", pr(0), 32'd0);
    chk("t5_async_busy", 32'(bus0.busy), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus0.out_valid === 1'b1) seen = 1'b1;
    end
    chk("t5_no_valid", 32'(seen), 32'd0);
    chk("t5_in_ready", ir(0), 32'd1);
    chk("t5_product_zero", pr(0), 32'd0);
    run_op(0, 8'd4, 8'd12, 48, W, "t5_4x12");

    // Back-to-back with in_valid and out_ready held high
    pa = int'($urandom_range(0, 255));
    pb = int'($urandom_range(0, 255));
    set_in(0, 1'b1, pa[7:0], pb[7:0]);
    set_ordy(0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      wait_valid(0, cyc);
      chk("t6_b2b_latency", 32'(cyc), 32'(W + 1));
      chk("t6_b2b_product", pr(0), 32'(pa * pb));
      pa = int'($urandom_range(0, 255));
      pb = int'($urandom_range(0, 255));
      set_in(0, (i != 15), pa[7:0], pb[7:0]);
      step();
    end
    set_ordy(0, 1'b0);
    step();
    chk("t6_end_idle", 32'(bus0.busy), 32'd0);

    // Early-exit instance
    run_op(1, 8'd167, 8'd1,   167,   1, "ee_b1");
    run_op(1, 8'd13,  8'd6,   78,    3, "ee_b6");
    run_op(1, 8'd200, 8'd128, 25600, W, "ee_b128");
    run_op(1, 8'd255, 8'd255, 65025, W, "ee_255x255");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
